// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO decode, register
// offsets, console status bit positions and a byte-lane merge helper.
package dmem_pkg;

  localparam int MMIO_SEL_BIT = 31;

  localparam logic [7:0] OFF_GPIO           = 8'h00;
  localparam logic [7:0] OFF_CONSOLE_TX     = 8'h04;
  localparam logic [7:0] OFF_CONSOLE_STATUS = 8'h08;
  localparam logic [7:0] OFF_CYCLE_LO       = 8'h10;
  localparam logic [7:0] OFF_CYCLE_HI       = 8'h14;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 4;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO feeding the console sink: valid/ready drain, full/empty/count
// status and a sticky overflow flag with write-one-to-clear.
module console_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_push,
  input  logic [7:0]                      i_push_data,
  input  logic                            i_pop_ready,
  input  logic                            i_clr_overflow,
  output logic                            o_valid,
  output logic [7:0]                      o_data,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(FIFO_DEPTH):0]     o_count,
  output logic                            o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign o_full     = (r_count == CW'(FIFO_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_valid    = !o_empty;
  assign o_data     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_pop     = o_valid && i_pop_ready;
  assign w_push_ok = i_push && (!o_full || w_pop);
  assign w_drop    = i_push && o_full && !w_pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_drop)              r_overflow <= 1'b1;
      else if (i_clr_overflow) r_overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus MMIO (GPIO, console FIFO,
// 64-bit cycle counter) with a zero-latency combinational read path.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  parameter int    FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic [3:0]  byteEnable,
  output logic [31:0] RD_data,
  output logic [31:0] gpio_out,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] r_ram [DEPTH_WORDS];
  logic [31:0] r_gpio;
  logic [63:0] r_cycle;

  logic          w_is_mmio;
  logic [AW-1:0] w_ram_idx;
  logic [7:0]    w_off;
  logic          w_mmio_wr;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_fifo_overflow;
  logic [CW-1:0] w_fifo_count;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_is_mmio = ALUResultM[MMIO_SEL_BIT];
  assign w_ram_idx = ALUResultM[AW+1:2];
  assign w_off     = ALUResultM[7:0];
  assign w_mmio_wr = MemWriteM && w_is_mmio;
  assign w_unused  = &{1'b0, ALUResultM[30:AW+2]};

  // NOTE: the RAM has no reset branch; clearing a large array would block
  // block-RAM inference, and its contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (MemWriteM && !w_is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEnable[i]) r_ram[w_ram_idx][8*i +: 8] <= WriteDataM[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gpio  <= '0;
      r_cycle <= '0;
    end else begin
      if (w_mmio_wr && w_off == OFF_GPIO)
        r_gpio <= merge_bytes(r_gpio, WriteDataM, byteEnable);
      r_cycle <= r_cycle + 64'd1;
    end
  end

  assign gpio_out = r_gpio;

  console_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_console_fifo (
    .clk            (clk),
    .rst_n          (reset),
    .i_push         (w_mmio_wr && w_off == OFF_CONSOLE_TX && byteEnable[0]),
    .i_push_data    (WriteDataM[7:0]),
    .i_pop_ready    (console_ready),
    .i_clr_overflow (w_mmio_wr && w_off == OFF_CONSOLE_STATUS && byteEnable[0]
                     && WriteDataM[ST_OVERFLOW]),
    .o_valid        (console_valid),
    .o_data         (console_data),
    .o_full         (w_fifo_full),
    .o_empty        (w_fifo_empty),
    .o_count        (w_fifo_count),
    .o_overflow     (w_fifo_overflow)
  );

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_status                          = '0;
    w_status[ST_FULL]                 = w_fifo_full;
    w_status[ST_EMPTY]                = w_fifo_empty;
    w_status[ST_OVERFLOW]             = w_fifo_overflow;
    w_status[ST_COUNT_LSB +: 4]       = 4'(w_fifo_count);
  end

  always_comb begin
    RD_data = '0;
    if (!w_is_mmio) begin
      RD_data = r_ram[w_ram_idx];
    end else begin
      case (w_off)
        OFF_GPIO:           RD_data = r_gpio;
        OFF_CONSOLE_STATUS: RD_data = w_status;
        OFF_CYCLE_LO:       RD_data = r_cycle[31:0];
        OFF_CYCLE_HI:       RD_data = r_cycle[63:32];
        default:            RD_data = '0;
      endcase
    end
  end

endmodule
